compact_inv_bf: RTL and testbench

// - Radix-4 inverse-NTT butterfly: two cascaded Gentleman-Sande (GS) stages over Z_q, q = 3329.
// - Inverse counterpart of the forward compact radix-4 butterfly; sits in the INTT datapath between coefficient RAM read and write-back.
// - Fully pipelined, one 4-coefficient beat per cycle, valid/ready handshake on both sides.

---
 rtl/compact_inv_bf.sv | 145 ++++++++++++++
 tb/tb_compact_inv_bf.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/compact_inv_bf.sv
// compact_inv_bf: radix-4 inverse-NTT butterfly (two cascaded Gentleman-Sande stages mod Q), 6-stage pipeline.
// Optional macro INV_BF_SCALE_EN multiplies every stage output by 2^-1 mod Q (folds n^-1 into the INTT).
module compact_inv_bf #(
    parameter int DATA_WIDTH = 12,
    parameter int Q          = 3329,
    parameter int BARRETT_M  = 5039
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] u0,
    input  logic [DATA_WIDTH-1:0] v0,
    input  logic [DATA_WIDTH-1:0] u1,
    input  logic [DATA_WIDTH-1:0] v1,
    input  logic [DATA_WIDTH-1:0] wi1,
    input  logic [DATA_WIDTH-1:0] wi2,
    input  logic [DATA_WIDTH-1:0] wi3,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] bf_0_upper,
    output logic [DATA_WIDTH-1:0] bf_0_lower,
    output logic [DATA_WIDTH-1:0] bf_1_upper,
    output logic [DATA_WIDTH-1:0] bf_1_lower
);
    localparam int PW = 2 * DATA_WIDTH;
    localparam int MW = $clog2(BARRETT_M + 1);
    localparam logic [DATA_WIDTH:0] Q_E = (DATA_WIDTH + 1)'(Q);
    localparam logic [PW-1:0]       Q_P = PW'(Q);
    localparam logic [MW-1:0]       M_E = MW'(BARRETT_M);

    function automatic logic [DATA_WIDTH-1:0] mod_add(input logic [DATA_WIDTH-1:0] x,
                                                      input logic [DATA_WIDTH-1:0] y);
        logic [DATA_WIDTH:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= Q_E) s = s - Q_E;
        return DATA_WIDTH'(s);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] mod_sub(input logic [DATA_WIDTH-1:0] x,
                                                      input logic [DATA_WIDTH-1:0] y);
        logic signed [DATA_WIDTH+1:0] d;
        d = $signed({2'b00, x}) - $signed({2'b00, y});
        if (d < 0) d = d + $signed({1'b0, Q_E});
        return DATA_WIDTH'(d);
    endfunction

    // Quotient estimate undershoots by at most one, so a single -Q gives the exact residue.
    function automatic logic [DATA_WIDTH-1:0] barrett(input logic [PW-1:0] x);
        logic [PW+MW-1:0] t;
        logic [MW-1:0]    qh;
        logic [PW-1:0]    r;
        t  = {{MW{1'b0}}, x} * {{PW{1'b0}}, M_E};
        qh = MW'(t >> PW);
        r  = x - PW'(qh) * Q_P;
        if (r >= Q_P) r = r - Q_P;
        return DATA_WIDTH'(r);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] halve(input logic [DATA_WIDTH-1:0] x);
`ifdef INV_BF_SCALE_EN
        logic [DATA_WIDTH:0] t;
        t = {1'b0, x} + (x[0] ? Q_E : '0);
        return DATA_WIDTH'(t >> 1);
`else
        return x;
`endif
    endfunction

    logic                  w_en;
    logic                  r_vld_p1, r_vld_p2, r_vld_p3, r_vld_p4, r_vld_p5, r_vld_p6;
    logic [DATA_WIDTH-1:0] r_s0_p1, r_d0_p1, r_s1_p1, r_d1_p1, r_w1_p1, r_w2_p1, r_w3_p1;
    logic [DATA_WIDTH-1:0] r_s0_p2, r_s1_p2, r_w3_p2;
    logic [PW-1:0]         r_m0_p2, r_m1_p2;
    logic [DATA_WIDTH-1:0] r_a0_p3, r_a1_p3, r_b0_p3, r_b1_p3, r_w3_p3;
    logic [DATA_WIDTH-1:0] r_t0_p4, r_t1_p4, r_t2_p4, r_t3_p4, r_w3_p4;
    logic [DATA_WIDTH-1:0] r_t0_p5, r_t2_p5;
    logic [PW-1:0]         r_m2_p5, r_m3_p5;
    logic [DATA_WIDTH-1:0] r_y0_p6, r_y1_p6, r_y2_p6, r_y3_p6;

    // A held output beat freezes every stage, bubbles included.
    assign w_en     = !(r_vld_p6 && !out_ready);
    assign in_ready = w_en;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            {r_vld_p1, r_vld_p2, r_vld_p3, r_vld_p4, r_vld_p5, r_vld_p6} <= '0;
            {r_s0_p1, r_d0_p1, r_s1_p1, r_d1_p1, r_w1_p1, r_w2_p1, r_w3_p1} <= '0;
            {r_s0_p2, r_s1_p2, r_w3_p2, r_m0_p2, r_m1_p2} <= '0;
            {r_a0_p3, r_a1_p3, r_b0_p3, r_b1_p3, r_w3_p3} <= '0;
            {r_t0_p4, r_t1_p4, r_t2_p4, r_t3_p4, r_w3_p4} <= '0;
            {r_t0_p5, r_t2_p5, r_m2_p5, r_m3_p5} <= '0;
            {r_y0_p6, r_y1_p6, r_y2_p6, r_y3_p6} <= '0;
        end else if (w_en) begin
            // S1: first-stage add/sub
            r_vld_p1 <= in_valid;
            r_s0_p1  <= mod_add(u0, v0);
            r_d0_p1  <= mod_sub(u0, v0);
            r_s1_p1  <= mod_add(u1, v1);
            r_d1_p1  <= mod_sub(u1, v1);
            r_w1_p1  <= wi1;
            r_w2_p1  <= wi2;
            r_w3_p1  <= wi3;
            // S2: first-stage twiddle products, sums delayed
            r_vld_p2 <= r_vld_p1;
            r_s0_p2  <= r_s0_p1;
            r_s1_p2  <= r_s1_p1;
            r_m0_p2  <= PW'(r_d0_p1) * PW'(r_w1_p1);
            r_m1_p2  <= PW'(r_d1_p1) * PW'(r_w2_p1);
            r_w3_p2  <= r_w3_p1;
            // S3: reduce and optional halve
            r_vld_p3 <= r_vld_p2;
            r_a0_p3  <= halve(r_s0_p2);
            r_a1_p3  <= halve(barrett(r_m0_p2));
            r_b0_p3  <= halve(r_s1_p2);
            r_b1_p3  <= halve(barrett(r_m1_p2));
            r_w3_p3  <= r_w3_p2;
            // S4: second-stage add/sub
            r_vld_p4 <= r_vld_p3;
            r_t0_p4  <= mod_add(r_a0_p3, r_b0_p3);
            r_t1_p4  <= mod_sub(r_a0_p3, r_b0_p3);
            r_t2_p4  <= mod_add(r_a1_p3, r_b1_p3);
            r_t3_p4  <= mod_sub(r_a1_p3, r_b1_p3);
            r_w3_p4  <= r_w3_p3;
            // S5: second-stage twiddle products
            r_vld_p5 <= r_vld_p4;
            r_t0_p5  <= r_t0_p4;
            r_t2_p5  <= r_t2_p4;
            r_m2_p5  <= PW'(r_t1_p4) * PW'(r_w3_p4);
            r_m3_p5  <= PW'(r_t3_p4) * PW'(r_w3_p4);
            // S6: reduce and optional halve
            r_vld_p6 <= r_vld_p5;
            r_y0_p6  <= halve(r_t0_p5);
            r_y1_p6  <= halve(r_t2_p5);
            r_y2_p6  <= halve(barrett(r_m2_p5));
            r_y3_p6  <= halve(barrett(r_m3_p5));
        end
    end

    assign out_valid  = r_vld_p6;
    assign bf_0_upper = r_y0_p6;
    assign bf_0_lower = r_y2_p6;
    assign bf_1_upper = r_y1_p6;
    assign bf_1_lower = r_y3_p6;
endmodule

// File: tb/tb_compact_inv_bf.sv
// Self-checking bench for compact_inv_bf: scoreboard of reference results pushed on accept, popped on output.
`timescale 1ns/1ps
module tb_compact_inv_bf;
    localparam int DW = 12;
    localparam int Q  = 3329;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready, out_valid, out_ready;
    logic [DW-1:0] u0, v0, u1, v1, wi1, wi2, wi3;
    logic [DW-1:0] bf_0_upper, bf_0_lower, bf_1_upper, bf_1_lower;

    always #5 clk = ~clk;

    compact_inv_bf dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .u0(u0), .v0(v0), .u1(u1), .v1(v1), .wi1(wi1), .wi2(wi2), .wi3(wi3),
        .out_valid(out_valid), .out_ready(out_ready),
        .bf_0_upper(bf_0_upper), .bf_0_lower(bf_0_lower),
        .bf_1_upper(bf_1_upper), .bf_1_lower(bf_1_lower)
    );

    int          nchk = 0;
    int          nerr = 0;
    logic [47:0] exp_q[$];
    logic [47:0] exp_v;
    logic        s_iready, s_ovalid, s_otx;
    logic [47:0] s_y;

    function automatic int md(input int x);
        return ((x % Q) + Q) % Q;
    endfunction

    function automatic int hv(input int x);
`ifdef INV_BF_SCALE_EN
        return md(x * 1665);
`else
        return x;
`endif
    endfunction

    function automatic logic [47:0] model(input logic [DW-1:0] a, b, c, d, e, f, g);
        int x0, x1, x2, x3, w1, w2, w3, a0, a1, b0, b1, y0, y1, y2, y3;
        x0 = int'(a); x1 = int'(b); x2 = int'(c); x3 = int'(d);
        w1 = int'(e); w2 = int'(f); w3 = int'(g);
        a0 = hv(md(x0 + x1)); a1 = hv(md((x0 - x1) * w1));
        b0 = hv(md(x2 + x3)); b1 = hv(md((x2 - x3) * w2));
        y0 = hv(md(a0 + b0)); y2 = hv(md((a0 - b0) * w3));
        y1 = hv(md(a1 + b1)); y3 = hv(md((a1 - b1) * w3));
        return {DW'(y0), DW'(y2), DW'(y1), DW'(y3)};
    endfunction

    task automatic rand_data();
        u0 = DW'($urandom_range(Q - 1)); v0 = DW'($urandom_range(Q - 1));
        u1 = DW'($urandom_range(Q - 1)); v1 = DW'($urandom_range(Q - 1));
        wi1 = DW'($urandom_range(Q - 1)); wi2 = DW'($urandom_range(Q - 1));
        wi3 = DW'($urandom_range(Q - 1));
    endtask

    // Inputs are set at the falling edge; observe settled outputs, record accept, advance one cycle.
    task automatic tick();
        #1;
        s_iready = in_ready;
        s_ovalid = out_valid;
        s_otx    = out_valid && out_ready;
        s_y      = {bf_0_upper, bf_0_lower, bf_1_upper, bf_1_lower};
        if (in_valid && in_ready) exp_q.push_back(model(u0, v0, u1, v1, wi1, wi2, wi3));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        u0 = '0; v0 = '0; u1 = '0; v1 = '0; wi1 = '0; wi2 = '0; wi3 = '0;
        repeat (2) @(negedge clk);
        #1;
        nchk++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL reset_out_valid got=%b req=0", out_valid); end
        nchk++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL reset_in_ready got=%b req=1", in_ready); end
        nchk++;
        if ({bf_0_upper, bf_0_lower, bf_1_upper, bf_1_lower} !== 48'h0) begin
            nerr++; $display("FAIL reset_data got=%h req=0", {bf_0_upper, bf_0_lower, bf_1_upper, bf_1_lower});
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_vectors();
        int          tv[3][7];
        logic [47:0] tc[3];
        int          lat;
        bit          found;
        tv[0] = '{1, 0, 0, 0, 1, 1, 1};
        tv[1] = '{0, 1, 0, 0, 1, 1, 1};
        tv[2] = '{2, 1, 0, 0, 17, 1, 1};
`ifdef INV_BF_SCALE_EN
        tc[0] = {12'd2497, 12'd2497, 12'd2497, 12'd2497};
`else
        tc[0] = {12'd1, 12'd1, 12'd1, 12'd1};
`endif
        tc[1] = {12'd1, 12'd1, 12'd3328, 12'd3328};
        tc[2] = {12'd3, 12'd3, 12'd17, 12'd17};
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            u0 = DW'(tv[k][0]); v0 = DW'(tv[k][1]); u1 = DW'(tv[k][2]); v1 = DW'(tv[k][3]);
            wi1 = DW'(tv[k][4]); wi2 = DW'(tv[k][5]); wi3 = DW'(tv[k][6]);
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            nchk++; if (s_iready !== 1'b1) begin nerr++; $display("FAIL vec%0d_accept got=%b req=1", k, s_iready); end
            found = 1'b0; lat = 0;
            for (int n = 1; n <= 20 && !found; n++) begin
                tick();
                if (s_ovalid) begin found = 1'b1; lat = n; end
            end
            nchk++;
            if (!found || lat != 6) begin nerr++; $display("FAIL vec%0d_latency got=%0d req=6", k, lat); end
            if (found && exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                nchk++; if (s_y !== exp_v) begin nerr++; $display("FAIL vec%0d_model got=%h req=%h", k, s_y, exp_v); end
`ifdef INV_BF_SCALE_EN
                if (k == 0) begin
`endif
                nchk++; if (s_y !== tc[k]) begin nerr++; $display("FAIL vec%0d_const got=%h req=%h", k, s_y, tc[k]); end
`ifdef INV_BF_SCALE_EN
                end
`endif
            end
        end
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        int first, last, nout;
        first = -1; last = -1; nout = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 60 && (c < 30 || exp_q.size() > 0); c++) begin
            in_valid = (c < 30);
            rand_data();
            tick();
            if (c < 30) begin
                nchk++; if (s_iready !== 1'b1) begin nerr++; $display("FAIL b2b_in_ready c=%0d got=%b req=1", c, s_iready); end
            end
            if (s_otx) begin
                nout++;
                if (first < 0) first = c;
                last = c;
                nchk++;
                if (exp_q.size() == 0) begin nerr++; $display("FAIL b2b_extra got=%h req=none", s_y); end
                else begin
                    exp_v = exp_q.pop_front();
                    if (s_y !== exp_v) begin nerr++; $display("FAIL b2b_data got=%h req=%h", s_y, exp_v); end
                end
            end
        end
        in_valid = 1'b0;
        nchk++; if (nout != 30) begin nerr++; $display("FAIL b2b_count got=%0d req=30", nout); end
        nchk++; if (last - first + 1 != 30) begin nerr++; $display("FAIL b2b_span got=%0d req=30", last - first + 1); end
        exp_q.delete();
    endtask

    task automatic test_stall();
        logic [47:0] held;
        bit          have;
        int          nout;
        have = 1'b0; nout = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 16; c++) begin
            in_valid = (c < 3) || (c >= 8);
            rand_data();
            tick();
            if (s_ovalid) begin
                if (!have) begin held = s_y; have = 1'b1; end
                nchk++; if (s_iready !== 1'b0) begin nerr++; $display("FAIL stall_in_ready c=%0d got=%b req=0", c, s_iready); end
                nchk++; if (s_y !== held) begin nerr++; $display("FAIL stall_hold c=%0d got=%h req=%h", c, s_y, held); end
            end
        end
        nchk++; if (!have) begin nerr++; $display("FAIL stall_no_output got=0 req=1"); end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (s_otx) begin
                nout++;
                nchk++;
                if (exp_q.size() == 0) begin nerr++; $display("FAIL stall_extra got=%h req=none", s_y); end
                else begin
                    exp_v = exp_q.pop_front();
                    if (s_y !== exp_v) begin nerr++; $display("FAIL stall_data got=%h req=%h", s_y, exp_v); end
                end
            end
        end
        nchk++; if (nout != 3) begin nerr++; $display("FAIL stall_count got=%0d req=3", nout); end
        exp_q.delete();
    endtask

    task automatic test_random();
        bit          prev_stall;
        logic [47:0] prev_y;
        int          c;
        prev_stall = 1'b0;
        c = 0;
        while (c < 300 || (exp_q.size() > 0 && c < 400)) begin
            in_valid  = (c < 300) && ($urandom_range(9) < 7);
            out_ready = (c >= 300) || ($urandom_range(9) < 6);
            rand_data();
            tick();
            if (prev_stall) begin
                nchk++;
                if (s_ovalid !== 1'b1 || s_y !== prev_y) begin
                    nerr++; $display("FAIL rnd_stable c=%0d got=%b/%h req=1/%h", c, s_ovalid, s_y, prev_y);
                end
            end
            if (s_otx) begin
                nchk++;
                if (exp_q.size() == 0) begin nerr++; $display("FAIL rnd_extra got=%h req=none", s_y); end
                else begin
                    exp_v = exp_q.pop_front();
                    if (s_y !== exp_v) begin nerr++; $display("FAIL rnd_data c=%0d got=%h req=%h", c, s_y, exp_v); end
                end
            end
            prev_stall = s_ovalid && !s_otx;
            prev_y = s_y;
            c++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        nchk++; if (exp_q.size() != 0) begin nerr++; $display("FAIL rnd_lost got=%0d req=0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_reset_midstream();
        bit stale;
        stale = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 7; c++) begin
            in_valid = 1'b1;
            rand_data();
            tick();
            if (s_otx) begin
                nchk++;
                exp_v = exp_q.pop_front();
                if (s_y !== exp_v) begin nerr++; $display("FAIL rstmid_data got=%h req=%h", s_y, exp_v); end
            end
        end
        in_valid = 1'b0;
        #1;
        nchk++; if (out_valid !== 1'b1) begin nerr++; $display("FAIL rstmid_prefill got=%b req=1", out_valid); end
        #1 rst = 1'b0;
        #1;
        nchk++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL rstmid_out_valid got=%b req=0", out_valid); end
        nchk++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL rstmid_in_ready got=%b req=1", in_ready); end
        nchk++;
        if ({bf_0_upper, bf_0_lower, bf_1_upper, bf_1_lower} !== 48'h0) begin
            nerr++; $display("FAIL rstmid_data0 got=%h req=0", {bf_0_upper, bf_0_lower, bf_1_upper, bf_1_lower});
        end
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (s_ovalid) stale = 1'b1;
        end
        nchk++; if (stale) begin nerr++; $display("FAIL rstmid_stale got=1 req=0"); end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_back_to_back();
        test_stall();
        test_random();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout req=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
